// File: rtl/j11bus_arb.sv
// Two-master (CPU / DMA) arbiter and address decoder for the 22-bit J11 system bus.
// Routes each granted cycle to memory or the I/O page; unanswered or out-of-range cycles complete as NXM.
module j11bus_arb #(
    parameter logic [21:0] MEMTOP  = 22'h3C0000,
    parameter int          TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic        m0_gp,
    input  logic        m0_irq,
    input  logic [21:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [21:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        io_req,
    output logic        io_wr,
    output logic        io_gp,
    output logic        io_irq,
    output logic [12:0] io_addr,
    output logic [15:0] io_wdata,
    input  logic        io_ack,
    input  logic [15:0] io_rdata,
    output logic        nxm,
    output logic [21:0] nxm_addr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] T_MEM    = 2'd0;
    localparam logic [1:0] T_IO     = 2'd1;
    localparam logic [1:0] T_NXM    = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    function automatic logic [1:0] f_decode(input logic gp, input logic irq, input logic [21:0] addr);
        if (gp || irq) begin
            f_decode = T_IO;
        end else if (addr[21:13] == 9'h1FF) begin
            f_decode = T_IO;
        end else if (addr < MEMTOP) begin
            f_decode = T_MEM;
        end else begin
            f_decode = T_NXM;
        end
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_pend;
    logic [1:0]  w_req;
    logic [1:0]  w_done_mask;
    logic [1:0]  w_pend_nxt;
    logic        r_rr;
    logic        r_sel;
    logic        r_wr;
    logic [1:0]  r_tgt;
    logic [21:0] r_addr;
    logic [7:0]  r_cnt;
    logic        w_grant;
    logic        w_gsel;
    logic        w_g_wr;
    logic        w_g_gp;
    logic        w_g_irq;
    logic [21:0] w_g_addr;
    logic [15:0] w_g_wdata;
    logic [1:0]  w_g_tgt;
    logic        w_sack;
    logic [15:0] w_srdata;
    logic        w_done_nxm;
    logic [15:0] w_done_rdata;

    assign w_req = {m1_req, m0_req};

    // Pending flags: set by request pulses, the finishing master's flag cleared in DONE (a fresh pulse wins).
    always_comb begin
        w_done_mask = 2'b00;
        if (r_state == S_DONE) begin
            w_done_mask = r_sel ? 2'b10 : 2'b01;
        end else begin
            w_done_mask = 2'b00;
        end
        w_pend_nxt = (r_pend & ~w_done_mask) | w_req;
    end

    // Round-robin arbitration, evaluated only when no cycle is in flight.
    always_comb begin
        w_grant = 1'b0;
        w_gsel  = 1'b0;
        if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
            case (w_pend_nxt)
                2'b01:   begin w_grant = 1'b1; w_gsel = 1'b0; end
                2'b10:   begin w_grant = 1'b1; w_gsel = 1'b1; end
                2'b11:   begin w_grant = 1'b1; w_gsel = r_rr; end
                default: begin w_grant = 1'b0; w_gsel = 1'b0; end
            endcase
        end else begin
            w_grant = 1'b0;
            w_gsel  = 1'b0;
        end
    end

    // Attribute mux for the granted master; DMA cycles never carry gp/irq.
    always_comb begin
        w_g_wr    = 1'b0;
        w_g_gp    = 1'b0;
        w_g_irq   = 1'b0;
        w_g_addr  = 22'h000000;
        w_g_wdata = 16'h0000;
        if (w_gsel) begin
            w_g_wr    = m1_wr;
            w_g_addr  = m1_addr;
            w_g_wdata = m1_wdata;
        end else begin
            w_g_wr    = m0_wr;
            w_g_gp    = m0_gp;
            w_g_irq   = m0_irq;
            w_g_addr  = m0_addr;
            w_g_wdata = m0_wdata;
        end
        w_g_tgt = f_decode(w_g_gp, w_g_irq, w_g_addr);
    end

    // Only the decoded slave's ack and data are visible to the FSM.
    always_comb begin
        w_sack   = 1'b0;
        w_srdata = 16'h0000;
        case (r_tgt)
            T_MEM:   begin w_sack = mem_ack; w_srdata = mem_rdata; end
            T_IO:    begin w_sack = io_ack;  w_srdata = io_rdata;  end
            default: begin w_sack = 1'b0;    w_srdata = 16'h0000;  end
        endcase
    end

    // Next-state logic plus the completion status handed to the master in DONE.
    always_comb begin
        w_state_nxt  = r_state;
        w_done_nxm   = 1'b0;
        w_done_rdata = 16'h0000;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = w_grant ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                if (r_tgt == T_NXM) begin
                    w_state_nxt = S_DONE;
                    w_done_nxm  = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack in the final timeout cycle still wins over NXM.
                if (w_sack) begin
                    w_state_nxt  = S_DONE;
                    w_done_rdata = r_wr ? 16'h0000 : w_srdata;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                    w_done_nxm  = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                w_state_nxt = w_grant ? S_ISSUE : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping, decoded cycle attributes and the timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 2'b00;
            r_rr   <= 1'b0;
            r_sel  <= 1'b0;
            r_wr   <= 1'b0;
            r_tgt  <= T_MEM;
            r_addr <= 22'h000000;
            r_cnt  <= 8'h00;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_grant) begin
                r_rr   <= ~w_gsel;
                r_sel  <= w_gsel;
                r_wr   <= w_g_wr;
                r_tgt  <= w_g_tgt;
                r_addr <= w_g_addr;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= 8'h00;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'h01;
            end
        end
    end

    // Registered bus outputs: slave fields load on grant and hold through WAIT; master status loads on DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 22'h000000;
            mem_wdata <= 16'h0000;
            io_req    <= 1'b0;
            io_wr     <= 1'b0;
            io_gp     <= 1'b0;
            io_irq    <= 1'b0;
            io_addr   <= 13'h0000;
            io_wdata  <= 16'h0000;
            m0_ack    <= 1'b0;
            m0_rdata  <= 16'h0000;
            m1_ack    <= 1'b0;
            m1_rdata  <= 16'h0000;
            nxm       <= 1'b0;
            nxm_addr  <= 22'h000000;
        end else begin
            mem_req <= w_grant && (w_g_tgt == T_MEM);
            io_req  <= w_grant && (w_g_tgt == T_IO);
            if (w_grant) begin
                mem_wr    <= (w_g_tgt == T_MEM) ? w_g_wr    : 1'b0;
                mem_addr  <= (w_g_tgt == T_MEM) ? w_g_addr  : 22'h000000;
                mem_wdata <= (w_g_tgt == T_MEM) ? w_g_wdata : 16'h0000;
                io_wr     <= (w_g_tgt == T_IO)  ? w_g_wr          : 1'b0;
                io_gp     <= (w_g_tgt == T_IO)  ? w_g_gp          : 1'b0;
                io_irq    <= (w_g_tgt == T_IO)  ? w_g_irq         : 1'b0;
                io_addr   <= (w_g_tgt == T_IO)  ? w_g_addr[12:0]  : 13'h0000;
                io_wdata  <= (w_g_tgt == T_IO)  ? w_g_wdata       : 16'h0000;
            end else if (w_state_nxt != S_WAIT) begin
                mem_wr    <= 1'b0;
                mem_addr  <= 22'h000000;
                mem_wdata <= 16'h0000;
                io_wr     <= 1'b0;
                io_gp     <= 1'b0;
                io_irq    <= 1'b0;
                io_addr   <= 13'h0000;
                io_wdata  <= 16'h0000;
            end
            m0_ack <= (w_state_nxt == S_DONE) && !r_sel;
            m1_ack <= (w_state_nxt == S_DONE) && r_sel;
            nxm    <= (w_state_nxt == S_DONE) && w_done_nxm;
            if ((w_state_nxt == S_DONE) && !r_sel) begin
                m0_rdata <= w_done_rdata;
            end
            if ((w_state_nxt == S_DONE) && r_sel) begin
                m1_rdata <= w_done_rdata;
            end
            if ((w_state_nxt == S_DONE) && w_done_nxm) begin
                nxm_addr <= r_addr;
            end
        end
    end

endmodule

// File: tb/tb_j11bus_arb.sv
// Directed self-checking bench for j11bus_arb: decode, arbitration, timeout, NXM and reset.
module tb_j11bus_arb;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wr, m0_gp, m0_irq;
    logic [21:0] m0_addr;
    logic [15:0] m0_wdata;
    logic        m0_ack;
    logic [15:0] m0_rdata;
    logic        m1_req, m1_wr;
    logic [21:0] m1_addr;
    logic [15:0] m1_wdata;
    logic        m1_ack;
    logic [15:0] m1_rdata;
    logic        mem_req, mem_wr, mem_ack;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        io_req, io_wr, io_gp, io_irq, io_ack;
    logic [12:0] io_addr;
    logic [15:0] io_wdata, io_rdata;
    logic        nxm;
    logic [21:0] nxm_addr;

    int errors = 0;
    int checks = 0;
    int mem_req_cnt = 0;
    int io_req_cnt = 0;
    int snap_mem;
    int snap_io;
    logic no_early;

    j11bus_arb #(.MEMTOP(22'h3C0000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_gp(m0_gp), .m0_irq(m0_irq),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .io_req(io_req), .io_wr(io_wr), .io_gp(io_gp), .io_irq(io_irq),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata),
        .nxm(nxm), .nxm_addr(nxm_addr)
    );

    always #5 clk = ~clk;

    // Count slave request pulses.
    always @(posedge clk) begin
        if (mem_req) mem_req_cnt <= mem_req_cnt + 1;
        if (io_req)  io_req_cnt  <= io_req_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in a cycle where mem_req is visible; returns in the cycle the master ack is visible.
    task automatic serve_mem(input string tag, input logic [21:0] addr, input logic [15:0] rd);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_mem_addr"}, {10'd0, mem_addr}, {10'd0, addr});
        tick();
        mem_ack = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m0_wr = 1'b0; m0_gp = 1'b0; m0_irq = 1'b0;
        m0_addr = 22'h0; m0_wdata = 16'h0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 22'h0; m1_wdata = 16'h0;
        mem_ack = 1'b0; mem_rdata = 16'h0; io_ack = 1'b0; io_rdata = 16'h0;
        tick();
        tick();
        chk("reset_outputs", {31'd0, |{m0_ack, m0_rdata, m1_ack, m1_rdata, mem_req, mem_wr, mem_addr,
            mem_wdata, io_req, io_wr, io_gp, io_irq, io_addr, io_wdata, nxm, nxm_addr}}, 32'd0);
        rst = 1'b0;
        tick();

        // Memory read with ack three cycles after mem_req.
        snap_mem = mem_req_cnt;
        m0_req = 1'b1; m0_addr = 22'h001000; m0_wr = 1'b0;
        tick();
        m0_req = 1'b0;
        chk("rd_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rd_mem_addr", {10'd0, mem_addr}, 32'h001000);
        chk("rd_io_req", {31'd0, io_req}, 32'd0);
        tick(); tick(); tick();
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        chk("rd_ack", {31'd0, m0_ack}, 32'd1);
        chk("rd_rdata", {16'd0, m0_rdata}, 32'h1234);
        chk("rd_nxm", {31'd0, nxm}, 32'd0);
        tick();
        chk("rd_ack_pulse", {31'd0, m0_ack}, 32'd0);
        chk("rd_rdata_hold", {16'd0, m0_rdata}, 32'h1234);
        chk("rd_one_mem_req", mem_req_cnt - snap_mem, 32'd1);

        // DMA write into the I/O page.
        snap_mem = mem_req_cnt;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 22'h3FFF70; m1_wdata = 16'hA5A5;
        tick();
        m1_req = 1'b0;
        chk("io_req", {31'd0, io_req}, 32'd1);
        chk("io_addr", {19'd0, io_addr}, 32'h1F70);
        chk("io_wr", {31'd0, io_wr}, 32'd1);
        chk("io_wdata", {16'd0, io_wdata}, 32'hA5A5);
        tick();
        io_ack = 1'b1; io_rdata = 16'h5555;
        tick();
        io_ack = 1'b0; io_rdata = 16'h0;
        chk("io_m1_ack", {31'd0, m1_ack}, 32'd1);
        chk("io_m1_rdata_wr", {16'd0, m1_rdata}, 32'h0000);
        chk("io_no_mem_req", mem_req_cnt - snap_mem, 32'd0);
        chk("io_m0_rdata_indep", {16'd0, m0_rdata}, 32'h1234);
        m1_wr = 1'b0;
        tick();

        // GP cycle to address 0 goes to the I/O slave; a stray mem_ack is ignored.
        m0_req = 1'b1; m0_gp = 1'b1; m0_addr = 22'h000000;
        tick();
        m0_req = 1'b0;
        chk("gp_io_req", {31'd0, io_req}, 32'd1);
        chk("gp_io_gp", {31'd0, io_gp}, 32'd1);
        chk("gp_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        chk("gp_stray_ack", {31'd0, m0_ack}, 32'd0);
        io_ack = 1'b1; io_rdata = 16'hBEEF;
        tick();
        io_ack = 1'b0; io_rdata = 16'h0;
        chk("gp_ack", {31'd0, m0_ack}, 32'd1);
        chk("gp_rdata", {16'd0, m0_rdata}, 32'hBEEF);
        m0_gp = 1'b0;
        tick();

        // Contention straight after reset: m0 first, m1 issued two cycles after m0's slave ack.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_addr = 22'h000200; m1_addr = 22'h000400;
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        serve_mem("c1_m0", 22'h000200, 16'h1111);
        chk("c1_m0_ack", {31'd0, m0_ack}, 32'd1);
        chk("c1_m0_rdata", {16'd0, m0_rdata}, 32'h1111);
        tick();
        serve_mem("c1_m1", 22'h000400, 16'h2222);
        chk("c1_m1_ack", {31'd0, m1_ack}, 32'd1);
        chk("c1_m1_rdata", {16'd0, m1_rdata}, 32'h2222);
        tick();
        // A lone m0 cycle, then a repeat pair: m1 was not granted last, so it goes first.
        m0_addr = 22'h000600;
        m0_req = 1'b1;
        tick();
        m0_req = 1'b0;
        serve_mem("solo_m0", 22'h000600, 16'h3333);
        chk("solo_m0_ack", {31'd0, m0_ack}, 32'd1);
        tick();
        m0_addr = 22'h000200;
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        serve_mem("c2_m1", 22'h000400, 16'h4444);
        chk("c2_m1_ack", {31'd0, m1_ack}, 32'd1);
        chk("c2_m0_not_yet", {31'd0, m0_ack}, 32'd0);
        tick();
        serve_mem("c2_m0", 22'h000200, 16'h5555);
        chk("c2_m0_ack", {31'd0, m0_ack}, 32'd1);
        chk("c2_m0_rdata", {16'd0, m0_rdata}, 32'h5555);
        tick();

        // Timeout: no mem_ack, completion TO+1 cycles after mem_req.
        m0_addr = 22'h000100;
        m0_req = 1'b1;
        tick();
        m0_req = 1'b0;
        chk("to_mem_req", {31'd0, mem_req}, 32'd1);
        no_early = 1'b1;
        for (int i = 0; i < TO; i++) begin
            tick();
            if (m0_ack) no_early = 1'b0;
        end
        chk("to_no_early_ack", {31'd0, no_early}, 32'd1);
        tick();
        chk("to_ack", {31'd0, m0_ack}, 32'd1);
        chk("to_nxm", {31'd0, nxm}, 32'd1);
        chk("to_rdata", {16'd0, m0_rdata}, 32'h0000);
        chk("to_nxm_addr", {10'd0, nxm_addr}, 32'h000100);
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        tick();
        chk("to_late_ack", {31'd0, m0_ack | nxm}, 32'd0);

        // Ack in the exact timeout cycle wins.
        m0_addr = 22'h000300;
        m0_req = 1'b1;
        tick();
        m0_req = 1'b0;
        for (int i = 0; i < TO; i++) tick();
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        chk("edge_ack", {31'd0, m0_ack}, 32'd1);
        chk("edge_no_nxm", {31'd0, nxm}, 32'd0);
        chk("edge_rdata", {16'd0, m0_rdata}, 32'h7777);
        chk("edge_nxm_addr_held", {10'd0, nxm_addr}, 32'h000100);
        tick();

        // NXM-direct: no slave request, ack and nxm two cycles after the req.
        snap_mem = mem_req_cnt;
        snap_io = io_req_cnt;
        m0_addr = 22'h3C0000;
        m0_req = 1'b1;
        tick();
        m0_req = 1'b0;
        tick();
        chk("nxd_ack", {31'd0, m0_ack}, 32'd1);
        chk("nxd_nxm", {31'd0, nxm}, 32'd1);
        chk("nxd_nxm_addr", {10'd0, nxm_addr}, 32'h3C0000);
        chk("nxd_rdata", {16'd0, m0_rdata}, 32'h0000);
        chk("nxd_no_slave_req", (mem_req_cnt - snap_mem) + (io_req_cnt - snap_io), 32'd0);
        tick();

        // Reset during WAIT abandons the cycle; a later ack is ignored.
        m1_addr = 22'h000800;
        m1_req = 1'b1;
        tick();
        m1_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_outputs", {31'd0, |{m0_ack, m0_rdata, m1_ack, m1_rdata, mem_req, mem_wr, mem_addr,
            mem_wdata, io_req, io_wr, io_gp, io_irq, io_addr, io_wdata, nxm, nxm_addr}}, 32'd0);
        snap_mem = mem_req_cnt;
        mem_ack = 1'b1; mem_rdata = 16'h6666;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        no_early = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m1_ack || m0_ack) no_early = 1'b0;
        end
        chk("rstw_no_ack", {31'd0, no_early}, 32'd1);
        chk("rstw_no_reissue", mem_req_cnt - snap_mem, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
